// File: rtl/harris_pkg.sv
// Shared types, default geometry and width helpers for the Harris
// front end (frame sequencer and detector window addressing).
package harris_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      FLUSH,
      DONE
   } state_t;

   localparam int IMG_W_DEF       = 640;
   localparam int IMG_H_DEF       = 480;
   localparam int PIX_W_DEF       = 8;
   localparam int FLUSH_LINES_DEF = 2;

   // A counter that only ever holds 0 still needs one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int col_w(input int img_w);
      return cnt_w(img_w);
   endfunction

   function automatic int row_w(input int img_h, input int flush_lines);
      return cnt_w(img_h + flush_lines);
   endfunction

endpackage

// File: rtl/harris_pos_counter.sv
// Raster col/row position counter with clear, enable and wrap,
// flagging end of line, the last image row and the last row overall.
module harris_pos_counter #(
   parameter int COLS     = 4,
   parameter int ROWS     = 4,
   parameter int LAST_ROW = 2,
   parameter int COL_W    = 2,
   parameter int ROW_W    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [COL_W-1:0] col,
   output logic [ROW_W-1:0] row,
   output logic             eol,
   output logic             last_row,
   output logic             frame_end
);

   localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
   localparam logic [ROW_W-1:0] ROW_LST = ROW_W'(LAST_ROW);

   assign eol       = (col == COL_MAX);
   assign last_row  = (row == ROW_LST);
   assign frame_end = eol && (row == ROW_MAX);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         col <= '0;
         row <= '0;
      end else if (en) begin
         if (eol) begin
            col <= '0;
            row <= (row == ROW_MAX) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/harris_frame_sequencer.sv
// Frame controller feeding the Harris detector: tags source pixels,
// appends zero flush lines to drain line buffers, pulses frame_done.
module harris_frame_sequencer
   import harris_pkg::*;
#(
   parameter int IMG_W       = IMG_W_DEF,
   parameter int IMG_H       = IMG_H_DEF,
   parameter int PIX_W       = PIX_W_DEF,
   parameter int FLUSH_LINES = FLUSH_LINES_DEF,
   parameter int COL_W       = col_w(IMG_W),
   parameter int ROW_W       = row_w(IMG_H, FLUSH_LINES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [PIX_W-1:0] src_pixel,
   input  logic             src_valid,
   output logic             src_ready,
   output logic [PIX_W-1:0] pixel,
   output logic             pixel_valid,
   output logic [COL_W-1:0] pix_col,
   output logic [ROW_W-1:0] pix_row,
   output logic             sof,
   output logic             eol,
   output logic             eof,
   output logic             flushing,
   output logic             busy,
   output logic             frame_done
);

   state_t           state;
   state_t           nxt;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             at_eol;
   logic             at_last_row;
   logic             at_end;
   logic             cnt_en;
   logic             cnt_clr;
   logic             hs;
   logic             emit;

   assign src_ready = (state == STREAM);
   assign hs        = src_ready && src_valid;

   harris_pos_counter #(
      .COLS     (IMG_W),
      .ROWS     (IMG_H + FLUSH_LINES),
      .LAST_ROW (IMG_H - 1),
      .COL_W    (COL_W),
      .ROW_W    (ROW_W)
   ) u_pos (
      .clk       (clk),
      .reset     (reset),
      .clr       (cnt_clr),
      .en        (cnt_en),
      .col       (col),
      .row       (row),
      .eol       (at_eol),
      .last_row  (at_last_row),
      .frame_end (at_end)
   );

   always_comb begin
      nxt     = state;
      cnt_en  = 1'b0;
      cnt_clr = 1'b0;
      emit    = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               nxt     = STREAM;
               cnt_clr = 1'b1;
            end
         end
         STREAM: begin
            if (abort) begin
               nxt     = IDLE;
               cnt_clr = 1'b1;
            end else if (hs) begin
               cnt_en = 1'b1;
               emit   = 1'b1;
               if (at_eol && at_last_row)
                  nxt = (FLUSH_LINES > 0) ? FLUSH : DONE;
            end
         end
         FLUSH: begin
            if (abort) begin
               nxt     = IDLE;
               cnt_clr = 1'b1;
            end else begin
               cnt_en = 1'b1;
               emit   = 1'b1;
               if (at_end)
                  nxt = DONE;
            end
         end
         DONE: begin
            nxt     = IDLE;
            cnt_clr = 1'b1;
         end
         default: begin
            nxt     = IDLE;
            cnt_clr = 1'b1;
         end
      endcase
   end

   // Tags are captured from the counter before it advances, so every
   // marker lines up with the pixel it describes one cycle later.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pixel       <= '0;
         pixel_valid <= 1'b0;
         pix_col     <= '0;
         pix_row     <= '0;
         sof         <= 1'b0;
         eol         <= 1'b0;
         eof         <= 1'b0;
         flushing    <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         state       <= nxt;
         pixel_valid <= emit;
         pixel       <= (emit && state == STREAM) ? src_pixel : '0;
         pix_col     <= emit ? col : '0;
         pix_row     <= emit ? row : '0;
         sof         <= emit && (state == STREAM) &&
                        (col == '0) && (row == '0);
         eol         <= emit && at_eol;
         eof         <= emit && (state == STREAM) &&
                        at_eol && at_last_row;
         flushing    <= emit && (state == FLUSH);
         busy        <= emit || (nxt == STREAM) || (nxt == FLUSH);
         frame_done  <= (state == DONE);
      end
   end

endmodule

// File: doc/harris_frame_sequencer.md
Name: harris_frame_sequencer

Overview:
- Frame-level controller in front of the harrisDetector datapath.
- Accepts a raw 8-bit pixel stream from a source (file reader / DMA) over a valid/ready handshake.
- Drives the detector's `pixel`/`pixel_valid` inputs with row/column tags and frame markers.
- After the last real pixel, injects zero-valued flush lines to drain the detector's line buffers, then signals frame completion.

Parameters:
- IMG_W, 640, active pixels per line
- IMG_H, 480, active lines per frame
- PIX_W, 8, pixel width
- FLUSH_LINES, 2, zero lines appended after the frame (kernel radius); 0 disables flush
- COL_W, $clog2(IMG_W), column counter width
- ROW_W, $clog2(IMG_H+FLUSH_LINES), row counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begins a frame when idle
- abort  in  1  abandons the current frame, synchronous
- src_pixel  in  PIX_W  source pixel
- src_valid  in  1  source pixel valid
- src_ready  out  1  sequencer accepts source pixel
- pixel  out  PIX_W  to detector pixel input
- pixel_valid  out  1  to detector pixel_valid
- pix_col  out  COL_W  column of current output pixel
- pix_row  out  ROW_W  row of current output pixel
- sof  out  1  first pixel of frame
- eol  out  1  last pixel of a line (real or flush)
- eof  out  1  last real pixel of frame
- flushing  out  1  current output pixel is flush padding
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle completion pulse

Behaviour:
- Interface: one clock, `clk`; reset is synchronous and active-high, named `reset`.
- Reset values: every output is 0; state is IDLE; counters are 0.
- State IDLE:
  - src_ready=0, pixel_valid=0.
  - `start` moves to STREAM with col=row=0.
- State STREAM:
  - src_ready=1, busy=1.
  - Handshake occurs when src_valid && src_ready.
  - On a handshake, the next cycle has pixel=src_pixel and pixel_valid=1, tagged with that pixel's col/row. Latency is exactly 1 cycle, with all markers aligned to pixel_valid.
  - With no handshake, pixel_valid=0 next cycle and counters hold.
  - col wraps from IMG_W-1 to 0 and increments row.
  - sof fires at (0,0); eol fires at col=IMG_W-1; eof fires at (IMG_W-1, IMG_H-1).
  - Accepting the eof pixel moves to FLUSH if FLUSH_LINES>0, else to DONE. src_ready drops the cycle after eof is accepted.
- State FLUSH:
  - src_ready=0, busy=1, flushing=1 on each emitted pixel.
  - Emits pixel=0 with pixel_valid=1 every cycle for FLUSH_LINES*IMG_W cycles.
  - Rows continue from IMG_H; eol is asserted per flush line.
  - After the last flush pixel is emitted, moves to DONE.
- State DONE:
  - frame_done=1 and busy=0 for exactly one cycle, pixel_valid=0.
  - Returns to IDLE.
- start: ignored while busy or in DONE; start in the same cycle as reset is ignored.
- abort (STREAM or FLUSH): the next cycle is IDLE with pixel_valid=0 and all markers 0. No frame_done is issued; the partial frame is discarded. abort in IDLE has no effect.
- abort and start asserted together in IDLE: abort wins and the sequencer stays in IDLE.
- reset mid-frame: identical effect to abort, plus counters cleared.
- Source stall: src_valid gaps create pixel_valid gaps. The sequencer never emits duplicate pixels or invents real pixels.
- Width rules: counters are unsigned and never exceed IMG_W-1 or IMG_H+FLUSH_LINES-1. pixel is passed through unmodified, with no arithmetic.

Decomposition:
- Package harris_pkg holds:
  - the state enum (IDLE, STREAM, FLUSH, DONE),
  - default IMG_W, IMG_H, PIX_W, FLUSH_LINES,
  - the width-derivation functions.
- One sub-module, harris_pos_counter: col/row counter with enable, clear and wrap at IMG_W, producing eol plus the last-row compare. It is reused by the detector for window addressing.

Test Plan (IMG_W=4, IMG_H=3, FLUSH_LINES=1 unless noted):
- Reset check: hold reset 2 cycles -> all outputs 0, src_ready=0. Pulse start together with reset -> remains IDLE.
- Full frame: start, then src_valid continuous with pixels 1..12 -> pixel 1..12 each 1 cycle after its handshake.
  - sof with 1 at (0,0); eol with 4, 8, 12; eof with 12.
  - Then 4 zeros with flushing=1, row=3, eol on the 4th.
  - frame_done on the next cycle; busy low thereafter.
- Gapped source: src_valid every other cycle -> pixel_valid alternates, col/row advance only on valid pixels, sequence 1..12 intact.
- Start rules: start while busy -> no effect, no counter reset. Second start after frame_done -> new frame with sof at (0,0).
- Abort/reset: abort asserted after pixel 6 is accepted -> next cycle pixel_valid=0, busy=0, frame_done never asserted. Repeat with reset instead of abort -> same result.
- No flush: FLUSH_LINES=0 -> frame_done exactly 1 cycle after the eof pixel cycle, flushing never asserted.
